// File: rtl/gpr_bank.sv
// General-purpose register bank: two registered read ports, one write port,
// per-register busy scoreboard and a single-cycle shadow bank for context switches.
module gpr_bank #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 13,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              GPRLOAD,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] GPR_data,
  input  logic [ADDR_W-1:0] rop1,
  input  logic [ADDR_W-1:0] rop2,
  output logic [DATA_W-1:0] GPR_out1,
  output logic [DATA_W-1:0] GPR_out2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              ctx_save,
  input  logic              ctx_restore
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  // An address is live only if it exists and is not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < NUM_REGS_C);
    is_zero  = (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    return in_range && !is_zero;
  endfunction

  logic [DATA_W-1:0]   main_q   [NUM_REGS];
  logic [DATA_W-1:0]   main_d   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [DATA_W-1:0] gpr_out1_q, gpr_out1_d;
  logic [DATA_W-1:0] gpr_out2_q, gpr_out2_d;
  logic              busy1_q, busy1_d;
  logic              busy2_q, busy2_d;

  logic wr_ok_s;
  logic claim_ok_s;

  assign wr_ok_s    = GPRLOAD  && addr_live(wr_addr);
  assign claim_ok_s = claim_en && addr_live(claim_addr);

  // Next bank state: restore overrides save and write/claim; a claim beats a same-edge write clear.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      main_d[i]   = main_q[i];
      shadow_d[i] = shadow_q[i];
      busy_d[i]   = busy_q[i];
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      main_d[i] = ctx_restore ? shadow_q[i]
                : (wr_ok_s && (wr_addr == ADDR_W'(i))) ? GPR_data
                : main_q[i];
      busy_d[i] = ctx_restore ? 1'b0
                : (claim_ok_s && (claim_addr == ADDR_W'(i))) ? 1'b1
                : (wr_ok_s && (wr_addr == ADDR_W'(i))) ? 1'b0
                : busy_q[i];
      // Save sees the post-write value so a same-edge write is captured.
      shadow_d[i] = (ctx_save && !ctx_restore) ? main_d[i] : shadow_q[i];
    end
  end

  // Read ports look at next-state values, giving write-first and restore-first behaviour.
  always_comb begin
    gpr_out1_d = {DATA_W{1'b0}};
    gpr_out2_d = {DATA_W{1'b0}};
    busy1_d    = 1'b0;
    busy2_d    = 1'b0;
    if (addr_live(rop1)) begin
      gpr_out1_d = main_d[rop1];
      busy1_d    = busy_d[rop1];
    end else begin
      gpr_out1_d = {DATA_W{1'b0}};
      busy1_d    = 1'b0;
    end
    if (addr_live(rop2)) begin
      gpr_out2_d = main_d[rop2];
      busy2_d    = busy_d[rop2];
    end else begin
      gpr_out2_d = {DATA_W{1'b0}};
      busy2_d    = 1'b0;
    end
  end

  // State and output registers with synchronous reset taking precedence over everything.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        main_q[i]   <= {DATA_W{1'b0}};
        shadow_q[i] <= {DATA_W{1'b0}};
      end
      busy_q     <= {NUM_REGS{1'b0}};
      gpr_out1_q <= {DATA_W{1'b0}};
      gpr_out2_q <= {DATA_W{1'b0}};
      busy1_q    <= 1'b0;
      busy2_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        main_q[i]   <= main_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      busy_q     <= busy_d;
      gpr_out1_q <= gpr_out1_d;
      gpr_out2_q <= gpr_out2_d;
      busy1_q    <= busy1_d;
      busy2_q    <= busy2_d;
    end
  end

  assign GPR_out1 = gpr_out1_q;
  assign GPR_out2 = gpr_out2_q;
  assign busy1    = busy1_q;
  assign busy2    = busy2_q;

endmodule
